// File: rtl/aes_dec_engine_if.sv
// Shared control/flag structs and the valid/ready/data/strb stream interface
// used by the AES-128 decryption engine.
package mac_package;
  parameter int CNT_W = 16;

  typedef struct packed {
    logic             clear;
    logic             enable;
    logic             start;
    logic [CNT_W-1:0] len;
  } ctrl_t;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
  } flags_t;
endpackage

interface aes_dec_engine_if #(parameter int DATA_WIDTH = 32) ();
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/aes_dec_engine.sv
// AES-128 decryption engine: key and ciphertext in over 128-bit streams,
// plaintext out as four 32-bit beats, MS word first.
// Optional feature macro AES_DEC_KEY_REUSE_EN: when defined one key serves the
// whole job; otherwise a fresh key handshake and expansion precede every block.
// The inverse cipher core is iterative: 10 cycles of key expansion after kld,
// 10 round cycles after ld, then a 1-cycle done pulse with text_o valid.
module aes_inv_cipher_top (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [127:0] key_i,
  input  logic         kld_i,
  input  logic [127:0] blk_i,
  input  logic         ld_i,
  output logic         done_o,
  output logic [127:0] text_o
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction
  // Multiplicative inverse as x^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a; r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gm(p, p);
      r = gm(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] s);
    return ginv(rl(s, 1) ^ rl(s, 3) ^ rl(s, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < 10; i++) if (i < int'(r)) rc = xt(rc);
    return rc;
  endfunction
  function automatic logic [127:0] kfwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ subrot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  // Steps the schedule backwards: round key i -> round key i-1.
  function automatic logic [127:0] kinv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ subrot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t, m;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(r+4*c) -: 8] = isbox(s[127-8*(r+4*((c-r)&3)) -: 8]);
    t = t ^ rk;
    m = t;
    if (!last)
      for (int c = 0; c < 4; c++) begin
        a0 = t[127-32*c -: 8]; a1 = t[119-32*c -: 8];
        a2 = t[111-32*c -: 8]; a3 = t[103-32*c -: 8];
        m[127-32*c -: 32] = {
          gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
          gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
          gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
          gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
      end
    return m;
  endfunction

  logic [127:0] kreg, rk, st, rk_prev;
  logic [3:0]   krnd, drnd;
  logic         kbusy, dbusy;

  assign rk_prev = kinv(rk, rcon(drnd));
  assign text_o  = st;

  // Forward expansion leaves round key 10 in kreg; decryption walks it back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kreg <= '0; rk <= '0; st <= '0; krnd <= '0; drnd <= '0;
      kbusy <= 1'b0; dbusy <= 1'b0; done_o <= 1'b0;
    end else if (clr_i) begin
      kreg <= '0; rk <= '0; st <= '0; krnd <= '0; drnd <= '0;
      kbusy <= 1'b0; dbusy <= 1'b0; done_o <= 1'b0;
    end else if (en_i) begin
      done_o <= 1'b0;
      if (kld_i) begin
        kreg <= key_i; krnd <= 4'd1; kbusy <= 1'b1;
      end else if (kbusy) begin
        kreg <= kfwd(kreg, rcon(krnd));
        krnd <= krnd + 4'd1;
        if (krnd == 4'd10) kbusy <= 1'b0;
      end
      if (ld_i) begin
        st <= blk_i ^ kreg; rk <= kreg; drnd <= 4'd10; dbusy <= 1'b1;
      end else if (dbusy) begin
        st   <= inv_round(st, rk_prev, drnd == 4'd1);
        rk   <= rk_prev;
        drnd <= drnd - 4'd1;
        if (drnd == 4'd1) begin
          dbusy  <= 1'b0;
          done_o <= 1'b1;
        end
      end
    end
  end
endmodule

module aes_dec_engine
  import mac_package::*;
#(
  parameter int KEXP_CYCLES = 12,
  parameter int OUT_BEATS   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  aes_dec_engine_if.slave       c_i,
  aes_dec_engine_if.slave       k_i,
  aes_dec_engine_if.master      p_o,
  input  ctrl_t                 ctrl_i,
  output flags_t                flags_o
);
  localparam int IDX_W = $clog2(OUT_BEATS);
  localparam int KW    = $clog2(KEXP_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_WAIT, S_KEY_EXP, S_BLK_WAIT, S_DECRYPT, S_EMIT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [127:0]       r_key, r_ct, r_pt, core_text;
  logic [IDX_W-1:0]   idx_q;
  logic [KW-1:0]      kexp_q;
  logic [CNT_W-1:0]   cnt_q, len_q;
  logic               kld_q, ld_q, done_q, core_done;
  logic               k_hs, c_hs, p_hs, last_beat;
  logic               unused_strb;

  assign unused_strb = ^{c_i.strb, k_i.strb};
  assign k_hs        = k_i.valid & k_i.ready;
  assign c_hs        = c_i.valid & c_i.ready;
  assign p_hs        = p_o.valid & p_o.ready;
  assign last_beat   = idx_q == IDX_W'(OUT_BEATS - 1);
  assign p_o.data    = r_pt[127 - 32*idx_q -: 32];
  assign p_o.strb    = '1;
  assign flags_o     = '{cnt: cnt_q, busy: state_q != S_IDLE, done: done_q};

  aes_inv_cipher_top u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (ctrl_i.clear),
    .en_i   (ctrl_i.enable),
    .key_i  (r_key),
    .kld_i  (kld_q),
    .blk_i  (r_ct),
    .ld_i   (ld_q),
    .done_o (core_done),
    .text_o (core_text)
  );

  // Next state and state-only stream strobes; enable=0 freezes and silences all.
  always_comb begin
    state_d   = state_q;
    k_i.ready = 1'b0;
    c_i.ready = 1'b0;
    p_o.valid = 1'b0;
    case (state_q)
      S_IDLE:     if (ctrl_i.start) state_d = (ctrl_i.len == '0) ? S_DONE : S_KEY_WAIT;
      S_KEY_WAIT: begin
        k_i.ready = 1'b1;
        if (k_i.valid) state_d = S_KEY_EXP;
      end
      S_KEY_EXP:  if (kexp_q == KW'(KEXP_CYCLES - 1)) state_d = S_BLK_WAIT;
      S_BLK_WAIT: begin
        c_i.ready = 1'b1;
        if (c_i.valid) state_d = S_DECRYPT;
      end
      S_DECRYPT:  if (core_done) state_d = S_EMIT;
      S_EMIT: begin
        p_o.valid = 1'b1;
        if (p_o.ready && last_beat)
`ifdef AES_DEC_KEY_REUSE_EN
          state_d = (cnt_q + 1'b1 == len_q) ? S_DONE : S_BLK_WAIT;
`else
          state_d = (cnt_q + 1'b1 == len_q) ? S_DONE : S_KEY_WAIT;
`endif
      end
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (!ctrl_i.enable) begin
      state_d   = state_q;
      k_i.ready = 1'b0;
      c_i.ready = 1'b0;
      p_o.valid = 1'b0;
    end
  end

  // State, data latches, beat index and block counter; clear behaves like reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE; r_key <= '0; r_ct <= '0; r_pt <= '0; idx_q <= '0;
      kexp_q <= '0; cnt_q <= '0; len_q <= '0; kld_q <= 1'b0; ld_q <= 1'b0; done_q <= 1'b0;
    end else if (ctrl_i.clear) begin
      state_q <= S_IDLE; r_key <= '0; r_ct <= '0; r_pt <= '0; idx_q <= '0;
      kexp_q <= '0; cnt_q <= '0; len_q <= '0; kld_q <= 1'b0; ld_q <= 1'b0; done_q <= 1'b0;
    end else begin
      done_q <= ctrl_i.enable && state_q == S_DONE;
      if (ctrl_i.enable) begin
        state_q <= state_d;
        kld_q   <= k_hs;
        ld_q    <= c_hs;
        if (state_q == S_IDLE && ctrl_i.start) begin
          len_q <= ctrl_i.len;
          cnt_q <= '0;
        end
        if (k_hs) begin
          r_key  <= k_i.data;
          kexp_q <= '0;
        end else if (state_q == S_KEY_EXP) begin
          kexp_q <= kexp_q + 1'b1;
        end
        if (c_hs) r_ct <= c_i.data;
        if (state_q == S_DECRYPT && core_done) begin
          r_pt  <= core_text;
          idx_q <= '0;
        end
        if (p_hs) begin
          idx_q <= last_beat ? '0 : idx_q + 1'b1;
          if (last_beat) cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_dec_engine.sv
// Directed bench for aes_dec_engine using the FIPS-197 C.1 AES-128 vector.
module tb_aes_dec_engine;
  import mac_package::*;

  logic   clk = 1'b0;
  logic   rst_ni;
  ctrl_t  ctrl;
  flags_t flags;

  aes_dec_engine_if #(.DATA_WIDTH(128)) c_if ();
  aes_dec_engine_if #(.DATA_WIDTH(128)) k_if ();
  aes_dec_engine_if #(.DATA_WIDTH(32))  p_if ();

  aes_dec_engine dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .c_i     (c_if),
    .k_i     (k_if),
    .p_o     (p_if),
    .ctrl_i  (ctrl),
    .flags_o (flags)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int LAT = 10 + 2;  // 10-round iterative core + 2

  logic [31:0] pat [4];
  initial begin
    pat[0] = 32'h00112233; pat[1] = 32'h44556677;
    pat[2] = 32'h8899aabb; pat[3] = 32'hccddeeff;
  end

  // Passive monitor: handshakes and pulses as seen mid-cycle.
  int unsigned cyc = 0;
  int khs = 0, chs = 0, rdy_seen = 0, done_cnt = 0, done_cyc = 0;
  logic [31:0] beats[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (k_if.valid && k_if.ready) khs++;
    if (c_if.valid && c_if.ready) chs++;
    if (k_if.ready || c_if.ready) rdy_seen++;
    if (p_if.valid && p_if.ready) beats.push_back(p_if.data);
    if (flags.done) begin done_cnt++; done_cyc = cyc; end
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    int len;
    int n_beats;
    int n_khs;
  } vec_t;
  vec_t tv [3];

  int st_cyc, base_dur;

  task automatic start_job(input int len);
    @(posedge clk); #1;
    ctrl.len = CNT_W'(len); ctrl.start = 1'b1; st_cyc = cyc;
    @(posedge clk); #1;
    ctrl.start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string nm);
    int n = 0;
    while (done_cnt == d0 && n < 2000) begin @(negedge clk); n++; end
    chk({nm, "_done_seen"}, done_cnt != d0, 1);
  endtask

  task automatic chk_beats(input int b0, input int nb, input string nm);
    chk({nm, "_nbeats"}, beats.size() - b0, nb);
    for (int j = 0; j < nb && b0 + j < beats.size(); j++)
      chk($sformatf("%s_beat%0d", nm, j), beats[b0+j], pat[j%4]);
  endtask

  initial begin
    int b0, k0, c0, d0, r0, n;
    tv[0].len = 1; tv[0].n_beats = 4;  tv[0].n_khs = 1;
    tv[1].len = 3; tv[1].n_beats = 12;
    tv[2].len = 2; tv[2].n_beats = 8;
`ifdef AES_DEC_KEY_REUSE_EN
    tv[1].n_khs = 1; tv[2].n_khs = 1;
`else
    tv[1].n_khs = 3; tv[2].n_khs = 2;
`endif
    rst_ni = 1'b0;
    ctrl = '{clear: 1'b0, enable: 1'b1, start: 1'b0, len: '0};
    k_if.valid = 1'b0; k_if.data = KEY; k_if.strb = '1;
    c_if.valid = 1'b0; c_if.data = CT;  c_if.strb = '1;
    p_if.ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_flags", {flags.cnt, flags.busy, flags.done}, 0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_strobes", {k_if.ready, c_if.ready, p_if.valid}, 0);
    chk("rst_flags_after", {flags.cnt, flags.busy, flags.done}, 0);

    // T5: len=0 completes with no stream traffic; done two cycles after start.
    k_if.valid = 1'b1; c_if.valid = 1'b1;
    r0 = rdy_seen; k0 = khs; c0 = chs; d0 = done_cnt;
    @(posedge clk); #1 ctrl.len = '0; ctrl.start = 1'b1;
    @(posedge clk); #1 ctrl.start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!flags.done && n < 10);
    chk("len0_done_delay", n, 2);
    @(negedge clk);
    chk("len0_done_width", flags.done, 0);
    repeat (3) @(negedge clk);
    chk("len0_no_ready", rdy_seen - r0, 0);
    chk("len0_no_hs", (khs - k0) + (chs - c0), 0);
    chk("len0_one_done", done_cnt - d0, 1);

    // T1 latency: ciphertext handshake to first plaintext beat.
    b0 = beats.size(); d0 = done_cnt;
    start_job(1);
    n = 0;
    while (!(c_if.valid && c_if.ready) && n < 200) begin @(negedge clk); n++; end
    chk("lat_c_hs_seen", c_if.valid && c_if.ready, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!p_if.valid && n < 200);
    chk("lat_first_beat", n - 1, LAT);
    chk("lat_strb", p_if.strb, 4'hf);
    wait_done(d0, "lat");
    chk_beats(b0, 4, "lat");

    // T4: clear during DECRYPT aborts silently; cnt returns to 0.
    b0 = beats.size(); d0 = done_cnt;
    start_job(1);
    n = 0;
    while (!(c_if.valid && c_if.ready) && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(posedge clk);
    #1 ctrl.clear = 1'b1;
    @(posedge clk); #1 ctrl.clear = 1'b0;
    @(negedge clk);
    chk("clr_busy", flags.busy, 0);
    chk("clr_cnt", flags.cnt, 0);
    k_if.valid = 1'b0; c_if.valid = 1'b0;
    r0 = 0;
    repeat (20) begin @(negedge clk); if (p_if.valid) r0++; end
    chk("clr_no_valid", r0, 0);
    chk("clr_no_beats", beats.size() - b0, 0);
    chk("clr_no_done", done_cnt - d0, 0);

    // Table: fresh T1, T2 (len=3), len=2.
    for (int i = 0; i < 3; i++) begin
      b0 = beats.size(); k0 = khs; c0 = chs; d0 = done_cnt;
      k_if.valid = 1'b1; c_if.valid = 1'b1;
      start_job(tv[i].len);
      wait_done(d0, $sformatf("tv%0d", i));
      if (i == 0) base_dur = done_cyc - st_cyc;
      repeat (4) @(negedge clk);
      chk_beats(b0, tv[i].n_beats, $sformatf("tv%0d", i));
      chk($sformatf("tv%0d_khs", i), khs - k0, tv[i].n_khs);
      chk($sformatf("tv%0d_chs", i), chs - c0, tv[i].len);
      chk($sformatf("tv%0d_cnt", i), flags.cnt, tv[i].len);
      chk($sformatf("tv%0d_ndone", i), done_cnt - d0, 1);
      chk($sformatf("tv%0d_idle", i), flags.busy, 0);
      @(posedge clk); #1 k_if.valid = 1'b0; c_if.valid = 1'b0;
    end

    // T3: 10 cycles of backpressure on beat 2.
    b0 = beats.size(); d0 = done_cnt;
    k_if.valid = 1'b1; c_if.valid = 1'b1;
    start_job(1);
    n = 0;
    do begin @(negedge clk); n++; end
      while (!(p_if.valid && p_if.data == pat[1]) && n < 200);
    @(posedge clk); #1 p_if.ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", j), {p_if.valid, p_if.data}, {1'b1, pat[2]});
    end
    @(posedge clk); #1 p_if.ready = 1'b1;
    wait_done(d0, "bp");
    repeat (3) @(negedge clk);
    chk_beats(b0, 4, "bp");

    // T6: enable low for 5 cycles during key expansion delays the job by 5.
    b0 = beats.size(); d0 = done_cnt;
    start_job(1);
    n = 0;
    while (!(k_if.valid && k_if.ready) && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    @(posedge clk); #1 ctrl.enable = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk($sformatf("en_quiet%0d", j), {k_if.ready, c_if.ready, p_if.valid}, 0);
    end
    @(posedge clk); #1 ctrl.enable = 1'b1;
    wait_done(d0, "en");
    chk("en_delay", done_cyc - st_cyc, base_dur + 5);
    repeat (3) @(negedge clk);
    chk_beats(b0, 4, "en");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
